// File: rtl/axi_rd_arb2.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arb2
// Brief    : Two-requester AXI4 read arbiter sharing one 64-bit DRAM read
//            port; round-robin grant, one burst in flight, RLAST/RID checking.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arb2 #(
    parameter int P_AXI_IDWIDTH = 5
) (
    input  logic                     aclk,
    input  logic                     areset,
    // requester 0 (instruction fetch)
    input  logic [P_AXI_IDWIDTH-1:0] axis0_arid,
    input  logic [31:0]              axis0_araddr,
    input  logic [3:0]               axis0_arlen,
    input  logic [2:0]               axis0_arsize,
    input  logic [1:0]               axis0_arburst,
    input  logic                     axis0_arvalid,
    output logic                     axis0_arready,
    output logic [P_AXI_IDWIDTH-1:0] axis0_rid,
    output logic [63:0]              axis0_rdata,
    output logic [1:0]               axis0_rresp,
    output logic                     axis0_rlast,
    output logic                     axis0_rvalid,
    input  logic                     axis0_rready,
    // requester 1 (data / DMA)
    input  logic [P_AXI_IDWIDTH-1:0] axis1_arid,
    input  logic [31:0]              axis1_araddr,
    input  logic [3:0]               axis1_arlen,
    input  logic [2:0]               axis1_arsize,
    input  logic [1:0]               axis1_arburst,
    input  logic                     axis1_arvalid,
    output logic                     axis1_arready,
    output logic [P_AXI_IDWIDTH-1:0] axis1_rid,
    output logic [63:0]              axis1_rdata,
    output logic [1:0]               axis1_rresp,
    output logic                     axis1_rlast,
    output logic                     axis1_rvalid,
    input  logic                     axis1_rready,
    // DRAM-side master
    output logic [P_AXI_IDWIDTH:0]   axim_arid,
    output logic [31:0]              axim_araddr,
    output logic [3:0]               axim_arlen,
    output logic [2:0]               axim_arsize,
    output logic [1:0]               axim_arburst,
    output logic                     axim_arvalid,
    input  logic                     axim_arready,
    input  logic [P_AXI_IDWIDTH:0]   axim_rid,
    input  logic [63:0]              axim_rdata,
    input  logic [1:0]               axim_rresp,
    input  logic                     axim_rlast,
    input  logic                     axim_rvalid,
    output logic                     axim_rready,
    // status
    output logic                     busy,
    output logic                     err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    logic [1:0] r_state;
    logic       r_grant;
    logic       r_last;
    logic [3:0] r_beats;
    logic       r_err;

    logic w_in_addr;
    logic w_in_data;
    logic w_r_hs;
    logic w_bad_beat;

    assign w_in_addr = (r_state == c_ADDR);
    assign w_in_data = (r_state == c_DATA);

    // AR payload is taken straight from the granted requester, which holds it stable
    assign axim_arvalid = w_in_addr;
    assign axim_arid    = {r_grant, (r_grant ? axis1_arid : axis0_arid)};
    assign axim_araddr  = r_grant ? axis1_araddr  : axis0_araddr;
    assign axim_arlen   = r_grant ? axis1_arlen   : axis0_arlen;
    assign axim_arsize  = r_grant ? axis1_arsize  : axis0_arsize;
    assign axim_arburst = r_grant ? axis1_arburst : axis0_arburst;

    assign axis0_arready = w_in_addr & ~r_grant & axim_arready;
    assign axis1_arready = w_in_addr &  r_grant & axim_arready;

    // R routing follows the grant register, never the returned ID
    assign axim_rready  = w_in_data & (r_grant ? axis1_rready : axis0_rready);
    assign axis0_rvalid = w_in_data & ~r_grant & axim_rvalid;
    assign axis1_rvalid = w_in_data &  r_grant & axim_rvalid;

    assign axis0_rid   = axim_rid[P_AXI_IDWIDTH-1:0];
    assign axis1_rid   = axim_rid[P_AXI_IDWIDTH-1:0];
    assign axis0_rdata = axim_rdata;
    assign axis1_rdata = axim_rdata;
    assign axis0_rresp = axim_rresp;
    assign axis1_rresp = axim_rresp;
    assign axis0_rlast = axim_rlast;
    assign axis1_rlast = axim_rlast;

    assign busy = (r_state != c_IDLE);
    assign err  = r_err;

    assign w_r_hs     = axim_rvalid & axim_rready;
    assign w_bad_beat = (axim_rid[P_AXI_IDWIDTH] != r_grant) |
                        (axim_rlast != (r_beats == 4'd0));

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= c_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_beats <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (axis0_arvalid | axis1_arvalid) begin
                        r_grant <= (axis0_arvalid & axis1_arvalid) ? ~r_last : axis1_arvalid;
                        r_state <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (axim_arready) begin
                        r_beats <= r_grant ? axis1_arlen : axis0_arlen;
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_r_hs) begin
                        // a missing RLAST lets the counter wrap and the burst continue
                        r_beats <= r_beats - 4'd1;
                        if (w_bad_beat) begin
                            r_err <= 1'b1;
                        end
                        if (axim_rlast) begin
                            r_last  <= r_grant;
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arb2
// Brief    : Randomised bench for axi_rd_arb2 with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arb2;

    localparam int IDW = 5;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    addr;
        logic [3:0]     len;
    } req_t;

    typedef struct {
        int           cyc;
        logic [IDW:0] id;
        logic [31:0]  addr;
    } ar_rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           areset = 1'b1;
    logic [IDW-1:0] s_arid    [2];
    logic [31:0]    s_araddr  [2];
    logic [3:0]     s_arlen   [2];
    logic [2:0]     s_arsize  [2];
    logic [1:0]     s_arburst [2];
    logic           s_arvalid [2];
    logic           s_rready  [2];

    logic           axim_arready = 1'b0;
    logic [IDW:0]   axim_rid     = '0;
    logic [63:0]    axim_rdata   = '0;
    logic [1:0]     axim_rresp   = '0;
    logic           axim_rlast   = 1'b0;
    logic           axim_rvalid  = 1'b0;

    logic           axis0_arready, axis1_arready;
    logic [IDW-1:0] axis0_rid, axis1_rid;
    logic [63:0]    axis0_rdata, axis1_rdata;
    logic [1:0]     axis0_rresp, axis1_rresp;
    logic           axis0_rlast, axis1_rlast;
    logic           axis0_rvalid, axis1_rvalid;
    logic [IDW:0]   axim_arid;
    logic [31:0]    axim_araddr;
    logic [3:0]     axim_arlen;
    logic [2:0]     axim_arsize;
    logic [1:0]     axim_arburst;
    logic           axim_arvalid;
    logic           axim_rready;
    logic           busy, err;

    axi_rd_arb2 #(.P_AXI_IDWIDTH(IDW)) dut (
        .aclk(clk), .areset(areset),
        .axis0_arid(s_arid[0]), .axis0_araddr(s_araddr[0]), .axis0_arlen(s_arlen[0]),
        .axis0_arsize(s_arsize[0]), .axis0_arburst(s_arburst[0]), .axis0_arvalid(s_arvalid[0]),
        .axis0_arready(axis0_arready), .axis0_rid(axis0_rid), .axis0_rdata(axis0_rdata),
        .axis0_rresp(axis0_rresp), .axis0_rlast(axis0_rlast), .axis0_rvalid(axis0_rvalid),
        .axis0_rready(s_rready[0]),
        .axis1_arid(s_arid[1]), .axis1_araddr(s_araddr[1]), .axis1_arlen(s_arlen[1]),
        .axis1_arsize(s_arsize[1]), .axis1_arburst(s_arburst[1]), .axis1_arvalid(s_arvalid[1]),
        .axis1_arready(axis1_arready), .axis1_rid(axis1_rid), .axis1_rdata(axis1_rdata),
        .axis1_rresp(axis1_rresp), .axis1_rlast(axis1_rlast), .axis1_rvalid(axis1_rvalid),
        .axis1_rready(s_rready[1]),
        .axim_arid(axim_arid), .axim_araddr(axim_araddr), .axim_arlen(axim_arlen),
        .axim_arsize(axim_arsize), .axim_arburst(axim_arburst), .axim_arvalid(axim_arvalid),
        .axim_arready(axim_arready), .axim_rid(axim_rid), .axim_rdata(axim_rdata),
        .axim_rresp(axim_rresp), .axim_rlast(axim_rlast), .axim_rvalid(axim_rvalid),
        .axim_rready(axim_rready), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: one burst owner at a time ----------
    int m_owner = 0;
    bit m_ar_open = 1'b0;   // owner's AR is being offered downstream
    bit m_r_open  = 1'b0;   // owner's burst is returning data
    int m_prio    = 0;      // port that wins the next tie
    int m_left    = 0;      // beats still expected before RLAST (1..16)
    bit m_err     = 1'b0;

    task automatic compare_outputs();
        logic [1:0] e_arrdy;
        logic [1:0] e_rv;
        e_arrdy = 2'b00;
        e_rv    = 2'b00;
        if (m_ar_open) e_arrdy[m_owner] = axim_arready;
        if (m_r_open)  e_rv[m_owner]    = axim_rvalid;
        chk("busy",     busy,          m_ar_open || m_r_open);
        chk("arvalid",  axim_arvalid,  m_ar_open);
        chk("arready0", axis0_arready, e_arrdy[0]);
        chk("arready1", axis1_arready, e_arrdy[1]);
        chk("rvalid0",  axis0_rvalid,  e_rv[0]);
        chk("rvalid1",  axis1_rvalid,  e_rv[1]);
        chk("rready",   axim_rready,   m_r_open && s_rready[m_owner]);
        chk("err",      err,           m_err);
        if (m_ar_open) begin
            chk("arid",    axim_arid,    {m_owner[0], s_arid[m_owner]});
            chk("araddr",  axim_araddr,  s_araddr[m_owner]);
            chk("arlen",   axim_arlen,   s_arlen[m_owner]);
            chk("arsize",  axim_arsize,  s_arsize[m_owner]);
            chk("arburst", axim_arburst, s_arburst[m_owner]);
        end
        chk("rid0",   axis0_rid,   axim_rid[IDW-1:0]);
        chk("rid1",   axis1_rid,   axim_rid[IDW-1:0]);
        chk("rdata0", axis0_rdata, axim_rdata);
        chk("rdata1", axis1_rdata, axim_rdata);
        chk("rresp0", axis0_rresp, axim_rresp);
        chk("rresp1", axis1_rresp, axim_rresp);
        chk("rlast0", axis0_rlast, axim_rlast);
        chk("rlast1", axis1_rlast, axim_rlast);
    endtask

    task automatic advance_model();
        if (areset) begin
            m_ar_open = 1'b0; m_r_open = 1'b0; m_prio = 0;
            m_left = 0; m_err = 1'b0; m_owner = 0;
        end else if (m_ar_open) begin
            if (axim_arready) begin
                m_ar_open = 1'b0;
                m_r_open  = 1'b1;
                m_left    = int'(s_arlen[m_owner]) + 1;
            end
        end else if (m_r_open) begin
            if (axim_rvalid && s_rready[m_owner]) begin
                if (axim_rid[IDW] != m_owner[0] || axim_rlast != (m_left == 1)) m_err = 1'b1;
                m_left = (m_left == 1) ? 16 : m_left - 1;
                if (axim_rlast) begin
                    m_r_open = 1'b0;
                    m_prio   = 1 - m_owner;
                end
            end
        end else if (s_arvalid[0] || s_arvalid[1]) begin
            m_owner   = (s_arvalid[0] && s_arvalid[1]) ? m_prio : (s_arvalid[0] ? 0 : 1);
            m_ar_open = 1'b1;
        end
    endtask

    // ---------------- monitor statistics ----------------
    ar_rec_t ar_log[$];
    int  outstanding = 0;
    int  nbeat[2]    = '{0, 0};
    int  nrv0        = 0;
    int  n_rlast     = 0;
    int  rlast_cyc   = 0;
    int  fall_cyc    = 0;
    bit  prev_busy   = 1'b0;

    bit           hs_sar[2] = '{1'b0, 1'b0};
    bit           hs_mar    = 1'b0;
    bit           hs_r      = 1'b0;
    logic [IDW:0] hs_id     = '0;
    logic [3:0]   hs_len    = '0;

    always @(negedge clk) begin
        cyc++;
        if (chk_on) compare_outputs();
        if (areset) begin
            outstanding = 0;
        end else begin
            if (axim_arvalid && axim_arready) begin
                if (chk_on) chk("one_outstanding", outstanding, 0);
                ar_log.push_back('{cyc, axim_arid, axim_araddr});
                outstanding++;
            end
            if (axim_rvalid && axim_rready && axim_rlast) begin
                outstanding--;
                rlast_cyc = cyc;
                n_rlast++;
            end
            if (axis0_rvalid && s_rready[0]) nbeat[0]++;
            if (axis1_rvalid && s_rready[1]) nbeat[1]++;
            if (axis0_rvalid) nrv0++;
        end
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;
        advance_model();
        hs_sar[0] = s_arvalid[0] && axis0_arready;
        hs_sar[1] = s_arvalid[1] && axis1_arready;
        hs_mar    = axim_arvalid && axim_arready;
        hs_id     = axim_arid;
        hs_len    = axim_arlen;
        hs_r      = axim_rvalid && axim_rready;
    end

    // ---------------- stimulus: requesters and DRAM-side slave ----------------
    req_t rq0[$];
    req_t rq1[$];
    bit auto_req  = 1'b0;
    int req_pct   = 0;
    int ar_pct    = 100;
    int rv_pct    = 100;
    int rr_pct    = 100;
    int ar_low    = 0;
    bit rr_toggle[2] = '{1'b0, 1'b0};
    bit inj_early = 1'b0;
    bit inj_rid   = 1'b0;

    bit           s_active = 1'b0;
    logic [IDW:0] s_id     = '0;
    int           s_len    = 0;
    int           s_idx    = 0;
    bit           s_flip   = 1'b0;
    bit           s_early  = 1'b0;

    task automatic push_req(input int k, input logic [IDW-1:0] id, input logic [31:0] addr,
                            input logic [3:0] len);
        req_t r;
        r.id = id; r.addr = addr; r.len = len;
        if (k == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            s_arid[k] = '0; s_araddr[k] = '0; s_arlen[k] = '0; s_arsize[k] = '0;
            s_arburst[k] = '0; s_arvalid[k] = 1'b0; s_rready[k] = 1'b0;
        end
        forever begin
            @(posedge clk); #1;
            if (areset) begin
                s_arvalid[0] = 1'b0; s_arvalid[1] = 1'b0;
                s_active = 1'b0; axim_rvalid = 1'b0; axim_rlast = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    req_t r;
                    bit   got;
                    got = 1'b0;
                    if (s_arvalid[k] && hs_sar[k]) s_arvalid[k] = 1'b0;
                    if (!s_arvalid[k]) begin
                        if (k == 0 && rq0.size() > 0) begin r = rq0.pop_front(); got = 1'b1; end
                        else if (k == 1 && rq1.size() > 0) begin r = rq1.pop_front(); got = 1'b1; end
                        else if (auto_req && $urandom_range(99) < req_pct) begin
                            r.id = IDW'($urandom); r.addr = $urandom; r.len = 4'($urandom_range(15));
                            got = 1'b1;
                        end
                        s_arsize[k]  = 3'($urandom_range(7));
                        s_arburst[k] = 2'($urandom_range(3));
                        if (got) begin
                            s_arid[k] = r.id; s_araddr[k] = r.addr; s_arlen[k] = r.len;
                            s_arvalid[k] = 1'b1;
                        end else begin
                            s_arid[k] = IDW'($urandom); s_araddr[k] = $urandom;
                            s_arlen[k] = 4'($urandom_range(15));
                        end
                    end
                    if (rr_toggle[k]) s_rready[k] = ~s_rready[k];
                    else              s_rready[k] = ($urandom_range(99) < rr_pct);
                end
                if (hs_r && axim_rvalid) begin
                    if (axim_rlast) s_active = 1'b0;
                    else            s_idx++;
                    axim_rvalid = 1'b0;
                end
                if (hs_mar) begin
                    s_active = 1'b1; s_id = hs_id; s_len = int'(hs_len); s_idx = 0;
                    s_flip = inj_rid; inj_rid = 1'b0;
                    s_early = inj_early; inj_early = 1'b0;
                end
                if (!axim_rvalid) begin
                    axim_rdata = {$urandom, $urandom};
                    axim_rresp = 2'($urandom_range(3));
                    if (s_active && $urandom_range(99) < rv_pct) begin
                        axim_rvalid = 1'b1;
                        axim_rlast  = s_early ? (s_idx == 1) : (s_idx == s_len);
                        axim_rid    = s_flip ? (s_id ^ {1'b1, {IDW{1'b0}}}) : s_id;
                    end else begin
                        axim_rlast = 1'($urandom_range(1));
                        axim_rid   = (IDW+1)'($urandom);
                    end
                end
                if (ar_low > 0) begin
                    axim_arready = 1'b0;
                    ar_low--;
                end else begin
                    axim_arready = ($urandom_range(99) < ar_pct);
                end
            end
        end
    end

    // ---------------- directed sequence helpers ----------------
    task automatic sync();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        sync(); areset = 1'b1;
        sync(); areset = 1'b0;
    endtask

    task automatic set_rates(input int ar, input int rv, input int rr);
        ar_pct = ar; rv_pct = rv; rr_pct = rr;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (n < 3000 && !(busy === 1'b0 && rq0.size() == 0 && rq1.size() == 0 &&
                   !s_arvalid[0] && !s_arvalid[1] && !s_active && !axim_rvalid));
        chk({nm, "_timeout"}, n >= 3000, 0);
        @(negedge clk); #1;
    endtask

    initial begin
        int b0, b1, rv0, rl0;
        int n;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, rv0, rl0, n;
        repeat (3) @(posedge clk);
        #2 areset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", axim_arvalid, 0);
        chk("rst_rready", axim_rready, 0);
        chk("rst_err", err, 0);
        chk("rst_arready", {axis1_arready, axis0_arready}, 0);
        chk("rst_rvalid", {axis1_rvalid, axis0_rvalid}, 0);

        // single request on port 0
        sync();
        set_rates(100, 100, 100);
        ar_log.delete(); b0 = nbeat[0]; b1 = nbeat[1];
        push_req(0, 5'd5, 32'h0000_1000, 4'd3);
        wait_idle("single");
        chk("single_ar_count", ar_log.size(), 1);
        if (ar_log.size() > 0) begin
            chk("single_arid", ar_log[0].id, 6'h05);
            chk("single_araddr", ar_log[0].addr, 32'h0000_1000);
        end
        chk("single_beats0", nbeat[0] - b0, 4);
        chk("single_beats1", nbeat[1] - b1, 0);
        chk("single_err", err, 0);
        chk("single_busy_drop", fall_cyc - rlast_cyc, 1);

        // simultaneous requests from a fresh reset: round-robin 0,1,0,1
        do_reset();
        set_rates(70, 70, 80);
        ar_log.delete();
        push_req(0, IDW'($urandom), $urandom, 4'($urandom_range(15)));
        push_req(0, IDW'($urandom), $urandom, 4'($urandom_range(15)));
        push_req(1, IDW'($urandom), $urandom, 4'($urandom_range(15)));
        push_req(1, IDW'($urandom), $urandom, 4'($urandom_range(15)));
        wait_idle("rr");
        chk("rr_ar_count", ar_log.size(), 4);
        for (int i = 0; i < ar_log.size() && i < 4; i++)
            chk("rr_grant_order", ar_log[i].id[IDW], i % 2);

        // backpressure on AR, toggling R ready on port 1
        sync();
        set_rates(100, 100, 100);
        ar_low = 5; rr_toggle[1] = 1'b1;
        b0 = nbeat[0]; b1 = nbeat[1]; rv0 = nrv0;
        push_req(1, 5'd9, 32'h0000_2040, 4'd5);
        wait_idle("bp");
        rr_toggle[1] = 1'b0;
        chk("bp_beats1", nbeat[1] - b1, 6);
        chk("bp_beats0", nbeat[0] - b0, 0);
        chk("bp_rvalid0_quiet", nrv0 - rv0, 0);

        // early RLAST
        do_reset();
        set_rates(100, 100, 100);
        inj_early = 1'b1;
        b0 = nbeat[0];
        push_req(0, 5'd1, 32'h0000_3000, 4'd3);
        wait_idle("early");
        chk("early_err", err, 1);
        chk("early_beats0", nbeat[0] - b0, 2);

        // wrong RID MSB while port 0 is granted
        do_reset();
        @(negedge clk); #1;
        chk("err_cleared", err, 0);
        sync();
        inj_rid = 1'b1;
        push_req(0, 5'd2, 32'h0000_4000, 4'd1);
        wait_idle("ridmsb");
        chk("ridmsb_err", err, 1);

        // reset in the middle of a burst
        do_reset();
        b0 = nbeat[0];
        push_req(0, 5'd3, 32'h0000_5000, 4'd7);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (n < 200 && nbeat[0] - b0 < 1);
        chk("midrst_wait_timeout", n >= 200, 0);
        sync(); areset = 1'b1;
        sync(); areset = 1'b0;
        @(negedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rready", axim_rready, 0);
        chk("midrst_err", err, 0);
        sync();
        b1 = nbeat[1]; ar_log.delete();
        push_req(1, 5'd4, 32'h0000_6000, 4'd2);
        wait_idle("midrst_new");
        chk("midrst_new_beats1", nbeat[1] - b1, 3);
        chk("midrst_new_err", err, 0);
        chk("midrst_new_ar", ar_log.size(), 1);

        // single-beat bursts alternating between ports
        sync();
        ar_log.delete(); rl0 = n_rlast;
        push_req(0, 5'd10, 32'h0000_7000, 4'd0);
        push_req(0, 5'd11, 32'h0000_7008, 4'd0);
        push_req(1, 5'd12, 32'h0000_8000, 4'd0);
        push_req(1, 5'd13, 32'h0000_8008, 4'd0);
        wait_idle("single_beat");
        chk("sb_ar_count", ar_log.size(), 4);
        chk("sb_rlasts", n_rlast - rl0, 4);
        chk("sb_err", err, 0);
        for (int i = 0; i < ar_log.size() && i < 4; i++) begin
            chk("sb_alternate", ar_log[i].id[IDW], i % 2);
            if (i > 0) chk("sb_spacing", ar_log[i].cyc - ar_log[i-1].cyc, 3);
        end

        // randomised traffic
        for (int seg = 0; seg < 8; seg++) begin
            sync();
            if ($urandom_range(3) == 0) do_reset();
            auto_req = 1'b1;
            req_pct  = 10 + int'($urandom_range(60));
            set_rates(30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)),
                      30 + int'($urandom_range(70)));
            inj_rid   = ($urandom_range(4) == 0);
            inj_early = ($urandom_range(4) == 0);
            repeat (400) @(posedge clk);
        end
        sync();
        auto_req = 1'b0;
        wait_idle("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
